fetch_unit: RTL

//  Instruction fetch stage, upstream of decode/execute. Holds the PC and issues in-order reads to instruction memory.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FQ_DEPTH    = 2;
  localparam int unsigned PC_INC      = 1;
  localparam int unsigned FETCH_PCW   = 32;
  localparam int unsigned FETCH_INSTW = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PCW-1:0]   pc;
    logic [FETCH_INSTW-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head is visible combinationally.
module fetch_queue #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Underflow/overflow requests are ignored; a full queue may push if it pops.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, in-order imem requests, redirect squash, decode handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   PCW      = 32,
  parameter int unsigned   INSTW    = 32,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_taken,
  input  logic [PCW-1:0]   branch_target,
  input  logic             stall,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PCW-1:0]   imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INSTW-1:0] imem_rsp_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [PCW-1:0]   if_pc,
  output logic [INSTW-1:0] if_inst
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned OW = PCW + INSTW;

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_nxt;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  drop_cnt_nxt;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  oq_count;
  logic [CW-1:0]  inflight_c;
  logic [PCW-1:0] pcq_head;
  logic [OW-1:0]  oq_head;
  logic           req_fire;
  logic           rsp_keep;
  logic           if_fire;

  // Issue only while the combined in-flight + delivered backlog fits the output queue.
  assign imem_req_valid = rst_n && (state == RUN) && !stall && !branch_taken &&
                          ((SW'(outstanding) + SW'(oq_count)) < SW'(FQ_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !branch_taken;
  assign if_valid = (oq_count != '0) && !branch_taken;
  assign if_fire  = if_valid && if_ready;
  assign if_pc    = oq_head[OW-1:INSTW];
  assign if_inst  = oq_head[INSTW-1:0];

  // Requests still owed a response after this cycle's accept and return.
  assign inflight_c = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  fetch_queue #(
    .W     (PCW),
    .DEPTH (FQ_DEPTH)
  ) u_pc_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head_c    (pcq_head),
    .count     (outstanding)
  );

  fetch_queue #(
    .W     (OW),
    .DEPTH (FQ_DEPTH)
  ) u_out_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (if_fire),
    .flush     (branch_taken),
    .head_c    (oq_head),
    .count     (oq_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  // Redirect overrides everything: reload pc and re-arm the drop count.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_cnt_nxt = drop_cnt;
    if (req_fire) pc_nxt = pc + PCW'(PC_INC);
    if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CW'(1);
    if ((state == FLUSH) && (drop_cnt_nxt == '0)) state_nxt = RUN;
    if (branch_taken) begin
      pc_nxt       = branch_target;
      drop_cnt_nxt = inflight_c;
      state_nxt    = (inflight_c != '0) ? FLUSH : RUN;
    end
  end

  // A response can only answer a request that was actually accepted.
  a_rsp_has_req : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

endmodule
